onehot_req_arbiter: RTL and testbench

Upstream stage of the 4-to-2 encoder. Captures rising edges on four independent request lines, keeps them pending, and issues exactly one one-hot grant at a time under round-robin priority. The one-hot output drives the encoder input directly, with a valid/ready handshake and a timeout that reclaims a stalled grant. Output is always zero or exactly one-hot, so the encoder never sees a multi-hot or ambiguous code while `valid_o` is high.

---
 rtl/onehot_req_arbiter_if.sv | 28 ++
 rtl/onehot_req_arbiter.sv | 116 +++++++++++
 tb/tb_onehot_req_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_req_arbiter_if.sv
// Request/grant bundle between the requesters, the arbiter and the downstream 4-to-2 encoder.
// The master side drives requests and ready. The slave side (the arbiter) drives the grant.
interface onehot_req_arbiter_if;
  logic [3:0] req_i;
  logic       ready_i;
  logic [3:0] onehot_o;
  logic       valid_o;
  logic [3:0] pending_o;
  logic       timeout_o;

  modport master (
    output req_i,
    output ready_i,
    input  onehot_o,
    input  valid_o,
    input  pending_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  ready_i,
    output onehot_o,
    output valid_o,
    output pending_o,
    output timeout_o
  );
endinterface

// File: rtl/onehot_req_arbiter.sv
// Round-robin arbiter: latches rising request edges as pending bits and issues one
// registered one-hot grant at a time, with valid/ready handshake and stall timeout.
module onehot_req_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  onehot_req_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam bit         TimeoutEn   = (TIMEOUT != 0);
  localparam logic [7:0] TimeoutLast = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] req_q;
  logic [3:0] pending_q, pending_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] onehot_q, onehot_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic [3:0] req_edge;
  logic [3:0] clr;
  logic [1:0] win_idx;
  logic [1:0] cand;

  assign req_edge = bus.req_i & ~req_q;

  // Scan from the farthest offset down so the nearest pending bit after ptr wins.
  always_comb begin
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (pending_q[cand]) win_idx = cand;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    onehot_d  = onehot_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    clr       = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (pending_q != 4'b0000) begin
          onehot_d = 4'b0001 << win_idx;
          valid_d  = 1'b1;
          idx_d    = win_idx;
          timer_d  = 8'd0;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        if (bus.ready_i) begin
          clr[idx_q] = 1'b1;
          onehot_d   = 4'b0000;
          valid_d    = 1'b0;
          ptr_d      = idx_q + 2'd1;
          state_d    = StIdle;
        end else if (TimeoutEn && (timer_q == TimeoutLast)) begin
          onehot_d  = 4'b0000;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = idx_q + 2'd1;
          state_d   = StIdle;
        end else if (TimeoutEn) begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new edge on the accepted line re-arms it in the same cycle.
    pending_d = (pending_q & ~clr) | req_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_q     <= 4'b0000;
      pending_q <= 4'b0000;
      ptr_q     <= 2'd0;
      idx_q     <= 2'd0;
      timer_q   <= 8'd0;
      onehot_q  <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= bus.req_i;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.onehot_o  = onehot_q;
  assign bus.valid_o   = valid_q;
  assign bus.pending_o = pending_q;
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Scoreboard bench for onehot_req_arbiter with TIMEOUT=4: directed stimulus pushes expected
// grants (code, cycles valid, timed out); a negedge monitor pops them as grants end.
module tb_onehot_req_arbiter;

  logic clk;
  logic rst_n;

  onehot_req_arbiter_if bus();

  onehot_req_arbiter #(
    .TIMEOUT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] oh;
    int         len;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] oh, input int len, input logic to);
    exp_t e;
    e.oh  = oh;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  task automatic chk_outs(input string name, input logic [3:0] oh, input logic v,
                          input logic [3:0] pend, input logic to);
    chk({name, "_onehot"}, {28'd0, bus.onehot_o}, {28'd0, oh});
    chk({name, "_valid"}, {31'd0, bus.valid_o}, {31'd0, v});
    chk({name, "_pending"}, {28'd0, bus.pending_o}, {28'd0, pend});
    chk({name, "_timeout"}, {31'd0, bus.timeout_o}, {31'd0, to});
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    bus.req_i   = 4'b0000;
    bus.ready_i = 1'b0;
    rst_n       = 1'b0;
    #2;
    chk_outs({name, "_in_reset"}, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk_outs({name, "_after_reset"}, 4'b0000, 1'b0, 4'b0000, 1'b0);
  endtask

  // Monitor: tracks each grant from valid rise to fall and scores it against the queue.
  logic       in_grant = 1'b0;
  logic [3:0] cur_oh   = 4'b0000;
  int         cur_len  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_grant = 1'b0;
    end else if (bus.valid_o) begin
      chk("mon_onehot_valid", {31'd0, $onehot(bus.onehot_o)}, 32'd1);
      if (!in_grant) begin
        in_grant = 1'b1;
        cur_oh   = bus.onehot_o;
        cur_len  = 1;
      end else begin
        chk("mon_grant_stable", {28'd0, bus.onehot_o}, {28'd0, cur_oh});
        cur_len++;
      end
    end else begin
      chk("mon_idle_zero", {28'd0, bus.onehot_o}, 32'd0);
      if (in_grant) begin
        in_grant = 1'b0;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL mon_unexpected_grant: got %b, expected no grant at %0t", cur_oh, $time);
        end else begin
          e = exp_q.pop_front();
          chk("mon_grant_code", {28'd0, cur_oh}, {28'd0, e.oh});
          chk("mon_grant_len", cur_len, e.len);
          chk("mon_grant_timeout", {31'd0, bus.timeout_o}, {31'd0, e.to});
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.req_i   = 4'b0000;
    bus.ready_i = 1'b0;

    // Reset and single request.
    do_reset("rst0");
    bus.ready_i = 1'b1;
    bus.req_i   = 4'b0001;
    push(4'b0001, 1, 1'b0);
    step(1);
    chk_outs("single_pend", 4'b0000, 1'b0, 4'b0001, 1'b0);
    bus.req_i = 4'b0000;
    step(1);
    chk_outs("single_grant", 4'b0001, 1'b1, 4'b0001, 1'b0);
    step(1);
    chk_outs("single_done", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Round-robin over all four lines.
    do_reset("rst_rr");
    bus.ready_i = 1'b1;
    bus.req_i   = 4'b1111;
    push(4'b0001, 1, 1'b0);
    push(4'b0010, 1, 1'b0);
    push(4'b0100, 1, 1'b0);
    push(4'b1000, 1, 1'b0);
    step(1);
    chk("rr_pend0", {28'd0, bus.pending_o}, 32'hf);
    begin
      logic [3:0] pend_tbl [4];
      logic [3:0] oh_tbl [4];
      pend_tbl = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
      oh_tbl   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int k = 0; k < 4; k++) begin
        step(1);
        chk("rr_valid", {31'd0, bus.valid_o}, 32'd1);
        chk("rr_onehot", {28'd0, bus.onehot_o}, {28'd0, oh_tbl[k]});
        step(1);
        chk("rr_gap", {31'd0, bus.valid_o}, 32'd0);
        chk("rr_pend", {28'd0, bus.pending_o}, {28'd0, pend_tbl[k]});
      end
    end
    bus.req_i = 4'b0000;

    // Wrap-around: after line 2, lines 0 and 3 together give 3 then 0.
    do_reset("rst_wrap");
    bus.ready_i = 1'b1;
    bus.req_i   = 4'b0100;
    push(4'b0100, 1, 1'b0);
    push(4'b1000, 1, 1'b0);
    push(4'b0001, 1, 1'b0);
    step(3);
    chk("wrap_pend_a", {28'd0, bus.pending_o}, 32'h0);
    bus.req_i = 4'b1001;
    step(1);
    chk("wrap_pend_b", {28'd0, bus.pending_o}, 32'h9);
    step(2);
    chk("wrap_pend_c", {28'd0, bus.pending_o}, 32'h1);
    step(2);
    chk("wrap_pend_d", {28'd0, bus.pending_o}, 32'h0);
    bus.req_i = 4'b0000;

    // Timeout on line 1, line 3 arrives during the stalled grant.
    do_reset("rst_to");
    bus.ready_i = 1'b0;
    bus.req_i   = 4'b0010;
    push(4'b0010, 4, 1'b1);
    push(4'b1000, 1, 1'b0);
    push(4'b0010, 1, 1'b0);
    step(2);
    chk_outs("to_grant", 4'b0010, 1'b1, 4'b0010, 1'b0);
    bus.req_i = 4'b1010;
    step(4);
    chk_outs("to_fire", 4'b0000, 1'b0, 4'b1010, 1'b1);
    step(1);
    chk_outs("to_next", 4'b1000, 1'b1, 4'b1010, 1'b0);
    bus.ready_i = 1'b1;
    step(1);
    chk_outs("to_acc3", 4'b0000, 1'b0, 4'b0010, 1'b0);
    step(1);
    chk_outs("to_regrant1", 4'b0010, 1'b1, 4'b0010, 1'b0);
    step(1);
    chk_outs("to_acc1", 4'b0000, 1'b0, 4'b0000, 1'b0);
    bus.req_i = 4'b0000;

    // Accept on the final timeout cycle wins over the timeout.
    do_reset("rst_edge");
    bus.ready_i = 1'b0;
    bus.req_i   = 4'b0001;
    push(4'b0001, 4, 1'b0);
    step(5);
    chk("last_valid", {31'd0, bus.valid_o}, 32'd1);
    bus.ready_i = 1'b1;
    step(1);
    chk_outs("last_acc", 4'b0000, 1'b0, 4'b0000, 1'b0);
    bus.req_i = 4'b0000;

    // Re-edge on line 0 landing on its accept cycle keeps it pending.
    do_reset("rst_sim");
    bus.ready_i = 1'b1;
    bus.req_i   = 4'b0001;
    push(4'b0001, 1, 1'b0);
    push(4'b0001, 1, 1'b0);
    step(1);
    bus.req_i = 4'b0000;
    step(1);
    chk("sim_grant", {28'd0, bus.onehot_o}, 32'h1);
    bus.req_i = 4'b0001;
    step(1);
    chk_outs("sim_acc", 4'b0000, 1'b0, 4'b0001, 1'b0);
    step(1);
    chk_outs("sim_regrant", 4'b0001, 1'b1, 4'b0001, 1'b0);
    step(1);
    chk_outs("sim_done", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Reset mid-grant abandons it without a timeout pulse.
    do_reset("rst_mid");
    bus.ready_i = 1'b0;
    bus.req_i   = 4'b0100;
    step(3);
    chk_outs("mid_grant", 4'b0100, 1'b1, 4'b0100, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_outs("mid_reset", 4'b0000, 1'b0, 4'b0000, 1'b0);
    step(2);
    bus.req_i = 4'b0000;
    rst_n     = 1'b1;
    step(3);
    chk_outs("mid_after", 4'b0000, 1'b0, 4'b0000, 1'b0);

    step(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
